// File: rtl/mcpu_ctrl.sv
// MCPU sequencing controller: instruction handshake, 4-entry register file,
// registered operand drive into MCPU_Alu and result/carry writeback.
module mcpu_ctrl #(
   parameter int CMD_SIZE  = 2,
   parameter int WORD_SIZE = 8,
   parameter int REG_AW    = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic                 instr_op,
   input  logic [CMD_SIZE-1:0]  instr_cmd,
   input  logic [REG_AW-1:0]    instr_rd,
   input  logic [REG_AW-1:0]    instr_rs1,
   input  logic [REG_AW-1:0]    instr_rs2,
   input  logic [WORD_SIZE-1:0] instr_imm,
   output logic [CMD_SIZE-1:0]  alu_cmd,
   output logic [WORD_SIZE-1:0] alu_in1,
   output logic [WORD_SIZE-1:0] alu_in2,
   input  logic [WORD_SIZE-1:0] alu_out,
   input  logic                 alu_cf,
   output logic                 wb_valid,
   output logic [REG_AW-1:0]    wb_rd,
   output logic [WORD_SIZE-1:0] wb_data,
   output logic                 carry,
   input  logic [REG_AW-1:0]    dbg_addr,
   output logic [WORD_SIZE-1:0] dbg_data
);

   localparam int NREG = 2 ** REG_AW;
   localparam logic [CMD_SIZE-1:0] CMD_ADD = CMD_SIZE'(3);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t                 state;
   state_t                 state_nx;
   logic                   accept;
   logic [REG_AW-1:0]      rd_q;
   logic [WORD_SIZE-1:0]   regs [NREG];

   assign accept   = instr_valid & instr_ready;
   assign dbg_data = regs[dbg_addr];

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (accept && !instr_op) state_nx = EXEC;
         EXEC:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      instr_ready = (state == IDLE);
   end

   // Operands are read at accept, so aliasing rd with rs1/rs2 is safe.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         carry    <= 1'b0;
         alu_cmd  <= '0;
         alu_in1  <= '0;
         alu_in2  <= '0;
         rd_q     <= '0;
         wb_valid <= 1'b0;
         wb_rd    <= '0;
         wb_data  <= '0;
      end else begin
         wb_valid <= 1'b0;
         if (accept) begin
            if (instr_op) begin
               regs[instr_rd] <= instr_imm;
               wb_valid       <= 1'b1;
               wb_rd          <= instr_rd;
               wb_data        <= instr_imm;
            end else begin
               alu_cmd <= instr_cmd;
               alu_in1 <= regs[instr_rs1];
               alu_in2 <= regs[instr_rs2];
               rd_q    <= instr_rd;
            end
         end else if (state == EXEC) begin
            regs[rd_q] <= alu_out;
            wb_valid   <= 1'b1;
            wb_rd      <= rd_q;
            wb_data    <= alu_out;
            if (alu_cmd == CMD_ADD) carry <= alu_cf;
         end
      end
   end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Bench for mcpu_ctrl: vector table of instructions plus writeback scoreboard,
// with a behavioural stand-in for MCPU_Alu.
module tb_mcpu_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       instr_valid;
   logic       instr_ready;
   logic       instr_op;
   logic [1:0] instr_cmd;
   logic [1:0] instr_rd, instr_rs1, instr_rs2;
   logic [7:0] instr_imm;
   logic [1:0] alu_cmd;
   logic [7:0] alu_in1, alu_in2;
   logic [7:0] alu_out;
   logic       alu_cf;
   logic       wb_valid;
   logic [1:0] wb_rd;
   logic [7:0] wb_data;
   logic       carry;
   logic [1:0] dbg_addr;
   logic [7:0] dbg_data;

   int tests = 0;
   int fails = 0;
   int wb_count = 0;
   int accepted = 0;
   logic [9:0] exp_q [$];

   always #5 clk = ~clk;

   mcpu_ctrl #(.CMD_SIZE(2), .WORD_SIZE(8), .REG_AW(2)) dut (
      .clk(clk), .resetn(resetn),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_cmd(instr_cmd),
      .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
      .instr_imm(instr_imm),
      .alu_cmd(alu_cmd), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_out(alu_out), .alu_cf(alu_cf),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .carry(carry), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Behavioural MCPU_Alu
   always_comb begin
      alu_cf  = 1'b0;
      alu_out = 8'h00;
      case (alu_cmd)
         2'd0: alu_out = alu_in1 & alu_in2;
         2'd1: alu_out = alu_in1 | alu_in2;
         2'd2: alu_out = alu_in1 ^ alu_in2;
         default: {alu_cf, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
      endcase
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] expd);
      tests++;
      if (act !== expd) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expd);
      end
   endtask

   always @(negedge clk) begin
      if (wb_valid === 1'b1) begin
         wb_count++;
         if (exp_q.size() == 0) begin
            check("wb_unexpected", {22'd0, wb_rd, wb_data}, 32'hFFFF_FFFF);
         end else begin
            check("wb_rd_data", {22'd0, wb_rd, wb_data},
                  {22'd0, exp_q.pop_front()});
         end
      end
   end

   typedef struct {
      logic       op;
      logic [1:0] cmd;
      logic [1:0] rd, rs1, rs2;
      logic [7:0] imm;
      logic [7:0] expd;
      logic       expc;
   } vec_t;

   vec_t vecs [13];

   function automatic vec_t mk(input logic op, input logic [1:0] cmd,
                               input logic [1:0] rd, input logic [1:0] rs1,
                               input logic [1:0] rs2, input logic [7:0] imm,
                               input logic [7:0] expd, input logic expc);
      vec_t v;
      v.op = op; v.cmd = cmd; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.imm = imm; v.expd = expd; v.expc = expc;
      return v;
   endfunction

   // Called just after a negedge; returns at the negedge after acceptance.
   task automatic issue(input logic op, input logic [1:0] cmd,
                        input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic [7:0] imm,
                        input logic [7:0] expd);
      int n;
      instr_op = op; instr_cmd = cmd; instr_rd = rd;
      instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
      instr_valid = 1'b1;
      exp_q.push_back({rd, expd});
      n = 0;
      while (instr_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("accept_timeout", 0, 1);
      @(posedge clk);
      accepted++;
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] a, input logic [7:0] expd,
                           input string name);
      dbg_addr = a;
      #1;
      check(name, {24'd0, dbg_data}, {24'd0, expd});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(1, 0, 0, 0, 0, 8'h3C, 8'h3C, 0);
      vecs[1]  = mk(1, 0, 1, 0, 0, 8'hA5, 8'hA5, 0);
      vecs[2]  = mk(0, 0, 2, 0, 1, 8'h00, 8'h24, 0);
      vecs[3]  = mk(0, 1, 3, 0, 1, 8'h00, 8'hBD, 0);
      vecs[4]  = mk(0, 2, 2, 0, 1, 8'h00, 8'h99, 0);
      vecs[5]  = mk(1, 0, 0, 0, 0, 8'hF0, 8'hF0, 0);
      vecs[6]  = mk(1, 0, 1, 0, 0, 8'h20, 8'h20, 0);
      vecs[7]  = mk(0, 3, 2, 0, 1, 8'h00, 8'h10, 1);
      vecs[8]  = mk(0, 3, 3, 1, 1, 8'h00, 8'h40, 0);
      vecs[9]  = mk(0, 2, 3, 3, 3, 8'h00, 8'h00, 0);
      vecs[10] = mk(1, 0, 1, 0, 0, 8'h81, 8'h81, 0);
      vecs[11] = mk(0, 3, 1, 1, 1, 8'h00, 8'h02, 1);
      vecs[12] = mk(0, 0, 0, 1, 1, 8'h00, 8'h02, 1);

      resetn = 1'b0; instr_valid = 1'b0; instr_op = 1'b0;
      instr_cmd = 2'd0; instr_rd = 2'd0; instr_rs1 = 2'd0;
      instr_rs2 = 2'd0; instr_imm = 8'h00; dbg_addr = 2'd0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) read_reg(2'(i), 8'h00, "reset_reg");
      check("reset_carry", {31'd0, carry}, 0);
      check("reset_ready", {31'd0, instr_ready}, 1);
      check("reset_wb_valid", {31'd0, wb_valid}, 0);
      check("reset_alu_in", {16'd0, alu_in1, alu_in2}, 0);
      @(negedge clk);

      // Consecutive loads are accepted on consecutive edges.
      for (int i = 0; i < 13; i++) begin
         issue(vecs[i].op, vecs[i].cmd, vecs[i].rd, vecs[i].rs1,
               vecs[i].rs2, vecs[i].imm, vecs[i].expd);
         if (vecs[i].op) begin
            check("load_wb_valid", {31'd0, wb_valid}, 1);
            check("load_ready", {31'd0, instr_ready}, 1);
         end else begin
            check("exec_ready_low", {31'd0, instr_ready}, 0);
            @(negedge clk);
            check("exec_ready_back", {31'd0, instr_ready}, 1);
            check("exec_wb_valid", {31'd0, wb_valid}, 1);
         end
         read_reg(vecs[i].rd, vecs[i].expd, "vec_reg");
         check("vec_carry", {31'd0, carry}, {31'd0, vecs[i].expc});
      end

      // Stall: second instruction held valid through EXEC.
      @(negedge clk);
      instr_op = 1'b0; instr_cmd = 2'd1; instr_rd = 2'd3;
      instr_rs1 = 2'd0; instr_rs2 = 2'd2; instr_valid = 1'b1;
      exp_q.push_back({2'd3, 8'h12});
      @(posedge clk);
      accepted++;
      @(negedge clk);
      check("stall_ready_low", {31'd0, instr_ready}, 0);
      instr_op = 1'b1; instr_rd = 2'd2; instr_imm = 8'h55;
      exp_q.push_back({2'd2, 8'h55});
      @(negedge clk);
      check("stall_ready_back", {31'd0, instr_ready}, 1);
      @(posedge clk);
      accepted++;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      read_reg(2'd3, 8'h12, "stall_r3");
      read_reg(2'd2, 8'h55, "stall_r2");
      check("stall_carry", {31'd0, carry}, 1);
      check("stall_wb_count", wb_count, accepted);

      // Reset while ADD r2,r0,r1 is in EXEC.
      @(negedge clk);
      instr_op = 1'b0; instr_cmd = 2'd3; instr_rd = 2'd2;
      instr_rs1 = 2'd0; instr_rs2 = 2'd1; instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      check("rst_mid_exec", {31'd0, instr_ready}, 0);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check("rst_mid_wb_valid", {31'd0, wb_valid}, 0);
      check("rst_mid_ready", {31'd0, instr_ready}, 1);
      check("rst_mid_carry", {31'd0, carry}, 0);
      for (int i = 0; i < 4; i++) read_reg(2'(i), 8'h00, "rst_mid_reg");
      repeat (3) @(negedge clk);
      check("final_wb_count", wb_count, accepted);
      check("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
